data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_pkg.sv | 40 ++++
 rtl/data_sram_responder_if.sv | 27 ++
 rtl/data_sram_responder_resp_fifo.sv | 62 ++++++
 rtl/data_sram_responder.sv | 69 ++++++
 tb/tb_data_sram_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared types and widths for the data-SRAM responder block.
// Holds response-entry layout, access size encodings and the strobe merge helper.
// No logic of its own; imported by the interface, the FIFO and the top.
package data_sram_responder_pkg;

  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int SIZE_W  = 2;
  // Wide enough for the largest legal LAT-1 (14).
  localparam int TIMER_W = 4;

  // Access size encodings carried on the bus (informational only here).
  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // One outstanding response: kind, captured read word, cycles left until due.
  typedef struct packed {
    logic               is_wr;
    logic [DATA_W-1:0]  data;
    logic [TIMER_W-1:0] timer;
  } resp_ent_t;

  // Replace the byte lanes of old_word selected by strb with lanes of new_word.
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-SRAM-like request/response bus between the EXE-side initiator and the responder.
// Address phase is req/addr_ok; data phase is a single data_ok pulse per request.
// Initiator never refuses data_ok; responder throttles only through addr_ok.
interface data_sram_responder_if;
  import data_sram_responder_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [STRB_W-1:0] wstrb;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response FIFO; each entry carries its own countdown timer.
// Pushed entry is visible at the head the next cycle; head_due is combinational from state.
// Caller must not push when full nor pop when head_due is low.
module resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        i_push,
  input  resp_ent_t                   i_push_ent,
  input  logic                        i_pop,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_head_due,
  output logic                        o_head_is_wr,
  output logic [DATA_W-1:0]           o_head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  resp_ent_t       r_ent [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // Pointers wrap naturally; count moves only when exactly one of push/pop fires.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Load the pushed slot; every other slot counts down and sticks at zero.
  // Free slots also count down, which is harmless since a push overwrites them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push && (r_wptr == PW'(i))) begin
        r_ent[i] <= i_push_ent;
      end else if (r_ent[i].timer != '0) begin
        r_ent[i].timer <= r_ent[i].timer - 1'b1;
      end
    end
  end

  assign o_count      = r_count;
  assign o_head_due   = (r_count != '0) && (r_ent[r_rptr].timer == '0);
  assign o_head_is_wr = r_ent[r_rptr].is_wr;
  assign o_head_data  = r_ent[r_rptr].data;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-masked writes / word reads on a local array, in-order responses.
// Latency: data_ok no earlier than LAT cycles after the address handshake.
// Backpressure: addr_ok drops while DEPTH requests are outstanding; hold_resp stalls the head.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int AW    = 10,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_hold_resp,
  data_sram_responder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [2**AW];

  logic [AW-1:0]     w_idx;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_head_due;
  logic              w_head_is_wr;
  logic [DATA_W-1:0] w_head_data;
  resp_ent_t         w_push_ent;
  logic              w_unused;

  // Only the word-index bits of addr select memory; size is carried for the initiator's benefit.
  assign w_unused = ^{bus.size, bus.addr};
  assign w_idx    = bus.addr[AW+1:2];

  // Acceptance uses the registered count only, so a same-cycle pop never frees a slot.
  assign bus.addr_ok = bus.req & (w_count < CW'(DEPTH));
  assign w_push      = bus.req & bus.addr_ok;
  assign w_pop       = w_head_due & ~i_hold_resp;

  // Reads capture the word now, so a later write cannot alter an already-accepted read.
  assign w_push_ent.is_wr = bus.wr;
  assign w_push_ent.data  = bus.wr ? '0 : r_mem[w_idx];
  assign w_push_ent.timer = TIMER_W'(LAT - 1);

  // Apply enabled byte lanes of an accepted write; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push && bus.wr) begin
      r_mem[w_idx] <= strb_merge(r_mem[w_idx], bus.wdata, bus.wstrb);
    end
  end

  resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .i_push       (w_push),
    .i_push_ent   (w_push_ent),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head_due   (w_head_due),
    .o_head_is_wr (w_head_is_wr),
    .o_head_data  (w_head_data)
  );

  assign bus.data_ok = w_pop;
  assign bus.rdata   = (w_pop && !w_head_is_wr) ? w_head_data : '0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: table of accesses with expected read data, scoreboard of due responses.
// Two responders: LAT=2 for the main checks, LAT=1 for the every-cycle streaming case.
// Drives inputs 1ns after posedge, samples outputs on negedge.
module tb_data_sram_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic hold_a;
  logic hold_b;

  always #5 clk = ~clk;

  data_sram_responder_if if_a ();
  data_sram_responder_if if_b ();

  data_sram_responder #(.AW(10), .LAT(LAT_A), .DEPTH(4)) u_dut_a (
    .clk(clk), .resetn(resetn), .i_hold_resp(hold_a), .bus(if_a)
  );

  data_sram_responder #(.AW(10), .LAT(LAT_B), .DEPTH(4)) u_dut_b (
    .clk(clk), .resetn(resetn), .i_hold_resp(hold_b), .bus(if_b)
  );

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t e_a;
  exp_t e_b;
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_tot  = 0;
  bit   exact_a = 1'b1;

  vec_t vecs [13];
  vec_t full_v [5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor for the LAT=2 responder.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (if_a.data_ok) begin
        if (sb_a.size() == 0) begin
          check("a_spurious_data_ok", 32'd1, 32'd0);
        end else begin
          e_a = sb_a.pop_front();
          check("a_rdata", if_a.rdata, e_a.rdata);
          if (exact_a) check("a_latency", 32'(cyc), 32'(e_a.due));
          else         check("a_latency_min", {31'd0, cyc >= e_a.due}, 32'd1);
        end
      end else begin
        check("a_idle_rdata", if_a.rdata, 32'd0);
      end
    end
  end

  // Response monitor for the LAT=1 responder (always exact timing).
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (if_b.data_ok) begin
        if (sb_b.size() == 0) begin
          check("b_spurious_data_ok", 32'd1, 32'd0);
        end else begin
          e_b = sb_b.pop_front();
          check("b_rdata", if_b.rdata, e_b.rdata);
          check("b_latency", 32'(cyc), 32'(e_b.due));
        end
      end else begin
        check("b_idle_rdata", if_b.rdata, 32'd0);
      end
    end
  end

  task automatic drive_a(input vec_t v);
    if_a.req   = 1'b1;
    if_a.wr    = v.wr;
    if_a.size  = 2'd2;
    if_a.addr  = v.addr;
    if_a.wdata = v.wdata;
    if_a.wstrb = v.wstrb;
  endtask

  // Present one request and wait (bounded) for its handshake; leaves req low afterwards.
  task automatic send_a(input vec_t v);
    bit ok = 1'b0;
    drive_a(v);
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (if_a.addr_ok) begin
        sb_a.push_back(exp_t'{v.exp, cyc + LAT_A});
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if_a.req = 1'b0;
    if (!ok) check("a_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_a();
    for (int k = 0; k < 100 && sb_a.size() != 0; k++) @(posedge clk);
    #1;
    if (sb_a.size() != 0) begin
      check("a_drain_timeout", 32'(sb_a.size()), 32'd0);
      sb_a.delete();
    end
  endtask

  task automatic drain_b();
    for (int k = 0; k < 100 && sb_b.size() != 0; k++) @(posedge clk);
    #1;
    if (sb_b.size() != 0) begin
      check("b_drain_timeout", 32'(sb_b.size()), 32'd0);
      sb_b.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    vecs[0]  = '{1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'h1122_3344};
    vecs[2]  = '{1'b1, 32'h0000_0100, 32'h00AB_0000, 4'h4, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0102, 32'h0,         4'h0, 32'h11AB_3344};
    vecs[4]  = '{1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0204, 32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0204, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0204, 32'h1234_5678, 4'h3, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0207, 32'h0,         4'h0, 32'hCAFE_5678};
    vecs[9]  = '{1'b1, 32'h0000_03FC, 32'h0102_0304, 4'hF, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_03FC, 32'hFF00_0000, 4'h8, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'hFF02_0304};
    vecs[12] = '{1'b0, 32'hAB00_1100, 32'h0,         4'h0, 32'h11AB_3344};

    full_v[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h11AB_3344};
    full_v[1] = '{1'b0, 32'h0000_0204, 32'h0, 4'h0, 32'hCAFE_5678};
    full_v[2] = '{1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'hFF02_0304};
    full_v[3] = '{1'b0, 32'h0000_1204, 32'h0, 4'h0, 32'hCAFE_5678};
    full_v[4] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h11AB_3344};

    resetn = 1'b0;
    hold_a = 1'b0;
    hold_b = 1'b0;
    if_a.req = 1'b0; if_a.wr = 1'b0; if_a.size = 2'd0; if_a.wstrb = 4'h0; if_a.addr = '0; if_a.wdata = '0;
    if_b.req = 1'b0; if_b.wr = 1'b0; if_b.size = 2'd0; if_b.wstrb = 4'h0; if_b.addr = '0; if_b.wdata = '0;

    // Reset state, sampled while reset is still held.
    @(posedge clk);
    @(negedge clk);
    check("rst_a_addr_ok", {31'd0, if_a.addr_ok}, 32'd0);
    check("rst_a_data_ok", {31'd0, if_a.data_ok}, 32'd0);
    check("rst_a_rdata",   if_a.rdata, 32'd0);
    check("rst_b_data_ok", {31'd0, if_b.data_ok}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Table pass 1: one request at a time, exact LAT=2 timing.
    for (int i = 0; i < 13; i++) begin
      send_a(vecs[i]);
      drain_a();
    end

    // Table pass 2: back-to-back requests, back-to-back responses.
    for (int i = 0; i < 13; i++) send_a(vecs[i]);
    drain_a();

    // Fill to DEPTH under hold_resp; fifth request must wait for the first pop.
    hold_a  = 1'b1;
    exact_a = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive_a(full_v[(k > 4) ? 4 : k]);
      @(negedge clk);
      check("full_addr_ok", {31'd0, if_a.addr_ok}, {31'd0, c < 4});
      if (if_a.addr_ok) begin
        sb_a.push_back(exp_t'{full_v[(k > 4) ? 4 : k].exp, cyc + LAT_A});
        k++;
      end
      @(posedge clk); #1;
    end
    hold_a = 1'b0;
    @(negedge clk);
    check("full_pop_addr_ok", {31'd0, if_a.addr_ok}, 32'd0);
    check("full_pop_data_ok", {31'd0, if_a.data_ok}, 32'd1);
    if (if_a.addr_ok) sb_a.push_back(exp_t'{full_v[4].exp, cyc + LAT_A});
    @(posedge clk); #1;
    @(negedge clk);
    check("full_refill_addr_ok", {31'd0, if_a.addr_ok}, 32'd1);
    if (if_a.addr_ok) sb_a.push_back(exp_t'{full_v[4].exp, cyc + LAT_A});
    @(posedge clk); #1;
    if_a.req = 1'b0;
    drain_a();
    exact_a = 1'b1;

    // Reset with three responses outstanding: all discarded, memory kept.
    send_a('{1'b1, 32'h0000_0300, 32'h0BAD_F00D, 4'hF, 32'h0});
    drain_a();
    hold_a = 1'b1;
    for (int i = 0; i < 3; i++) send_a('{1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0BAD_F00D});
    resetn = 1'b0;
    @(posedge clk); #1;
    sb_a.delete();
    hold_a = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_flush_data_ok", {31'd0, if_a.data_ok}, 32'd0);
      @(posedge clk); #1;
    end
    drive_a('{1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h0BAD_F00D});
    @(negedge clk);
    check("rst_next_addr_ok", {31'd0, if_a.addr_ok}, 32'd1);
    if (if_a.addr_ok) sb_a.push_back(exp_t'{32'h0BAD_F00D, cyc + LAT_A});
    @(posedge clk); #1;
    if_a.req = 1'b0;
    drain_a();

    // LAT=1 responder: two writes then a read every cycle, data_ok every cycle.
    for (int c = 0; c < 8; c++) begin
      if_b.req   = 1'b1;
      if_b.size  = 2'd2;
      if_b.wr    = (c < 2);
      if_b.addr  = (c % 2 == 0) ? 32'h0 : 32'h4;
      if_b.wdata = (c == 0) ? 32'h55AA_55AA : 32'h66BB_66BB;
      if_b.wstrb = 4'hF;
      @(negedge clk);
      check("b_addr_ok", {31'd0, if_b.addr_ok}, 32'd1);
      if (if_b.addr_ok) begin
        if (c < 2)            sb_b.push_back(exp_t'{32'h0, cyc + LAT_B});
        else if (c % 2 == 0)  sb_b.push_back(exp_t'{32'h55AA_55AA, cyc + LAT_B});
        else                  sb_b.push_back(exp_t'{32'h66BB_66BB, cyc + LAT_B});
      end
      @(posedge clk); #1;
    end
    if_b.req = 1'b0;
    drain_b();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
